m2_frame_sequencer: RTL and testbench

//  Sequences the M2 telemetry word filler: walks word positions 0..WORDS-1 of each group
//  and groups 1..GROUPS of each frame, issuing one buf_get_word strobe per position.
//  The filler's dataWord is forwarded to the serializer over a valid/ready handshake.

---
 rtl/m2_frame_sequencer.sv | 117 +++++++++++
 tb/tb_m2_frame_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m2_frame_sequencer.sv
// rtl/m2_frame_sequencer.sv - M2 telemetry word/group sequencer between filler and serializer
module m2_frame_sequencer #(
   parameter int WORDS  = 256,
   parameter int GROUPS = 32,
   parameter int DW     = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          resync,
   input  logic [DW-1:0] fill_data,
   input  logic          ser_ready,
   output logic          buf_get_word,
   output logic [7:0]    buf_rd_pointer,
   output logic          grp_oddity,
   output logic [4:0]    grp_num,
   output logic          word_valid,
   output logic [DW-1:0] word_data,
   output logic          frame_start,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_PRESENT,
      S_ADVANCE
   } state_t;

   localparam logic [7:0] PTR_LAST = 8'(WORDS - 1);
   // Group GROUPS is carried modulo 32, so with 32 groups the last group reads 0 on the 5-bit bus.
   localparam logic [4:0] GRP_LAST = 5'(GROUPS);

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_ptr;
   logic [7:0]    w_ptr_next;
   logic [4:0]    r_grp;
   logic [4:0]    w_grp_next;
   logic          r_resync_pend;
   logic          w_resync_pend_next;
   logic          w_resync_hit;
   logic [DW-1:0] r_word_data;

   // State register; reset abandons any word in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic: one strobe, one wait cycle, hold until handshake, then advance.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (enable)    w_state_next = S_FETCH;
         S_FETCH:                  w_state_next = S_WAIT;
         S_WAIT:                   w_state_next = S_PRESENT;
         S_PRESENT: if (ser_ready) w_state_next = S_ADVANCE;
         S_ADVANCE: w_state_next = enable ? S_FETCH : S_IDLE;
         default:                  w_state_next = S_IDLE;
      endcase
   end

   // Position update: pointer/group move only in ADVANCE, or on a resync while idle.
   always_comb begin
      w_ptr_next         = r_ptr;
      w_grp_next         = r_grp;
      w_resync_hit       = r_resync_pend | resync;
      w_resync_pend_next = w_resync_hit;
      if (r_state == S_IDLE && resync) begin
         w_ptr_next         = 8'd0;
         w_grp_next         = 5'd1;
         w_resync_pend_next = 1'b0;
      end else if (r_state == S_ADVANCE) begin
         w_resync_pend_next = 1'b0;
         if (w_resync_hit) begin
            w_ptr_next = 8'd0;
            w_grp_next = 5'd1;
         end else if (r_ptr == PTR_LAST) begin
            w_ptr_next = 8'd0;
            w_grp_next = (r_grp == GRP_LAST) ? 5'd1 : r_grp + 5'd1;
         end else begin
            w_ptr_next = r_ptr + 8'd1;
         end
      end
   end

   // Position and pending-resync registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr         <= 8'd0;
         r_grp         <= 5'd1;
         r_resync_pend <= 1'b0;
      end else begin
         r_ptr         <= w_ptr_next;
         r_grp         <= w_grp_next;
         r_resync_pend <= w_resync_pend_next;
      end
   end

   // Capture the filler word at the end of WAIT, once its register has loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 r_word_data <= '0;
      else if (r_state == S_WAIT) r_word_data <= fill_data;
   end

   assign buf_get_word   = (r_state == S_FETCH);
   assign word_valid     = (r_state == S_PRESENT);
   assign busy           = (r_state != S_IDLE);
   assign buf_rd_pointer = r_ptr;
   assign grp_num        = r_grp;
   assign grp_oddity     = r_grp[0];
   assign word_data      = r_word_data;
   assign frame_start    = word_valid && (r_ptr == 8'd0) && (r_grp == 5'd1);

endmodule

// File: tb/tb_m2_frame_sequencer.sv
// tb/tb_m2_frame_sequencer.sv - directed self-checking bench for m2_frame_sequencer
module tb_m2_frame_sequencer;

   localparam int DW = 12;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          enable    = 1'b0;
   logic          resync    = 1'b0;
   logic          ser_ready = 1'b1;
   logic [DW-1:0] fill_data = '0;
   logic          buf_get_word;
   logic [7:0]    buf_rd_pointer;
   logic          grp_oddity;
   logic [4:0]    grp_num;
   logic          word_valid;
   logic [DW-1:0] word_data;
   logic          frame_start;
   logic          busy;

   int checks      = 0;
   int failures    = 0;
   int cyc         = 0;
   int exp_ptr     = 0;
   int exp_grp     = 1;
   int fs_count    = 0;
   int last_strobe = 0;
   bit prev_strobe = 1'b0;

   m2_frame_sequencer #(.WORDS(256), .GROUPS(32), .DW(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .resync         (resync),
      .fill_data      (fill_data),
      .ser_ready      (ser_ready),
      .buf_get_word   (buf_get_word),
      .buf_rd_pointer (buf_rd_pointer),
      .grp_oddity     (grp_oddity),
      .grp_num        (grp_num),
      .word_valid     (word_valid),
      .word_data      (word_data),
      .frame_start    (frame_start),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] fdata(input int p, input int g);
      logic [3:0] gl;
      logic [7:0] pl;
      gl = 4'(g);
      pl = 8'(p);
      return {gl, pl};
   endfunction

   // Filler model: word is valid only during the cycle after the strobe.
   always @(negedge clk) begin
      fill_data   = prev_strobe ? fdata(int'(buf_rd_pointer), int'(grp_num)) : 12'hEEE;
      prev_strobe = buf_get_word;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strobe"}, 32'(buf_get_word), 32'd0);
      check({tag, "_ptr"},    32'(buf_rd_pointer), 32'd0);
      check({tag, "_grp"},    32'(grp_num), 32'd1);
      check({tag, "_odd"},    32'(grp_oddity), 32'd1);
      check({tag, "_valid"},  32'(word_valid), 32'd0);
      check({tag, "_data"},   32'(word_data), 32'd0);
      check({tag, "_fs"},     32'(frame_start), 32'd0);
      check({tag, "_busy"},   32'(busy), 32'd0);
   endtask

   task automatic wait_strobe();
      int n;
      n = 0;
      while (buf_get_word !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("strobe_timeout", 32'(n < 10), 32'd1);
   endtask

   task automatic model_advance();
      if (exp_ptr == 255) begin
         exp_ptr = 0;
         exp_grp = (exp_grp == 32) ? 1 : exp_grp + 1;
      end else begin
         exp_ptr = exp_ptr + 1;
      end
   endtask

   // One full word: strobe, wait, present (optionally stalled), handshake, advance.
   task automatic do_word(input int hold, input bit pulse_resync, input bit drop_en);
      logic [31:0] e_fs;
      e_fs = 32'((exp_ptr == 0) && (exp_grp == 1));
      wait_strobe();
      last_strobe = cyc;
      check("ptr",  32'(buf_rd_pointer), 32'(exp_ptr));
      check("grp",  32'(grp_num), 32'(exp_grp & 31));
      check("odd",  32'(grp_oddity), 32'(exp_grp & 1));
      @(negedge clk);
      check("strobe_once", 32'(buf_get_word), 32'd0);
      check("valid_wait",  32'(word_valid), 32'd0);
      if (pulse_resync) resync = 1'b1;
      if (drop_en)      enable = 1'b0;
      @(negedge clk);
      resync = 1'b0;
      check("valid",   32'(word_valid), 32'd1);
      check("latency", 32'(cyc - last_strobe), 32'd2);
      check("data",    32'(word_data), 32'(fdata(exp_ptr, exp_grp)));
      check("fs",      32'(frame_start), e_fs);
      if (frame_start === 1'b1) fs_count++;
      if (hold > 0) begin
         ser_ready = 1'b0;
         repeat (hold) @(negedge clk);
         check("hold_valid",  32'(word_valid), 32'd1);
         check("hold_data",   32'(word_data), 32'(fdata(exp_ptr, exp_grp)));
         check("hold_ptr",    32'(buf_rd_pointer), 32'(exp_ptr));
         check("hold_strobe", 32'(buf_get_word), 32'd0);
         ser_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", 32'(word_valid), 32'd0);
      check("fs_drop",    32'(frame_start), 32'd0);
      model_advance();
      if (pulse_resync) begin
         exp_ptr = 0;
         exp_grp = 1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t1;
      int t2;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");

      // 1: free-running start, strobe spacing and first-word frame_start
      reset  = 1'b1;
      enable = 1'b1;
      do_word(0, 1'b0, 1'b0); t0 = last_strobe;
      do_word(0, 1'b0, 1'b0); t1 = last_strobe;
      do_word(0, 1'b0, 1'b0); t2 = last_strobe;
      check("gap01", 32'(t1 - t0), 32'd4);
      check("gap12", 32'(t2 - t1), 32'd4);

      // 2: serializer back-pressure for 10 clocks
      do_word(10, 1'b0, 1'b0);

      // 3: one full frame plus one word, across every group wrap
      fs_count = 0;
      repeat (8193) do_word(0, 1'b0, 1'b0);
      check("fs_once", 32'(fs_count), 32'd1);

      // 4: resync at pointer 100 of group 7
      while (!(exp_ptr == 100 && exp_grp == 7)) do_word(0, 1'b0, 1'b0);
      do_word(0, 1'b1, 1'b0);
      do_word(0, 1'b0, 1'b0);

      // 5: enable dropped in WAIT at pointer 40, then resume
      while (exp_ptr != 40) do_word(0, 1'b0, 1'b0);
      do_word(0, 1'b0, 1'b1);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("idle_strobe", 32'(buf_get_word), 32'd0);
      check("idle_ptr",    32'(buf_rd_pointer), 32'd41);
      enable = 1'b1;
      do_word(0, 1'b0, 1'b0);

      // 6: reset asserted mid-PRESENT
      wait_strobe();
      @(negedge clk);
      ser_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 32'(word_valid), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset     = 1'b1;
      ser_ready = 1'b1;
      exp_ptr   = 0;
      exp_grp   = 1;
      do_word(0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
